frame_buf_pingpong: RTL

//  Double-buffered (ping-pong) frame memory, generalised from the single data memory.
//  Two banks of 2^ADDR_WIDTH x DATA_WIDTH words. The producer fills one bank while the

---
 rtl/frame_buf_pkg.sv | 14 +
 rtl/frame_buf_pingpong_if.sv | 30 +++
 rtl/frame_buf_bank.sv | 31 +++
 rtl/frame_buf_pingpong.sv | 120 ++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared types for the ping-pong frame buffer.
// FSM state encoding and bank index constants.
package frame_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    RUN     = 2'd1,
    WR_HOLD = 2'd2
  } state_e;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/frame_buf_pingpong_if.sv
// Producer/consumer bus for the ping-pong frame buffer.
// master = pixel writer + display read-out, slave = buffer.
interface frame_buf_pingpong_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_frame_done;
  logic                  wr_ready;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  rd_frame_done;
  logic                  rd_frame_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_frame_done,
    output rd_en, rd_addr, rd_frame_done,
    input  wr_ready, rd_data, rd_data_valid, rd_frame_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_frame_done,
    input  rd_en, rd_addr, rd_frame_done,
    output wr_ready, rd_data, rd_data_valid, rd_frame_valid
  );
endinterface

// File: rtl/frame_buf_bank.sv
// One frame bank: simple dual-port RAM, registered read.
// Ports: clk, reset (clears read reg only), we/waddr/wdata, re/raddr, rdata.
module frame_buf_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_buf_pingpong.sv
// Ping-pong frame memory: writer fills one bank, reader drains the other.
// Ports: clk, reset, bus (slave), frame_cnt when FRAME_CNT_EN is defined.
module frame_buf_pingpong
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
`ifdef FRAME_CNT_EN
  ,
  parameter int CNT_WIDTH  = 8
`endif
) (
  input  logic clk,
  input  logic reset,
`ifdef FRAME_CNT_EN
  output logic [CNT_WIDTH-1:0] frame_cnt,
`endif
  frame_buf_pingpong_if.slave bus
);
  state_e state_q, state_d;
  logic   wr_bank_q, wr_bank_d;
  logic   rd_bank;
  logic   wr_ready_q, rfv_q;
  logic   rd_sel_q, rd_valid_q;
  logic   swap, wr_fire, rd_fire;
  logic [DATA_WIDTH-1:0] q0, q1;

  assign rd_bank = ~wr_bank_q;
  assign wr_fire = bus.wr_en & wr_ready_q;
  assign rd_fire = bus.rd_en & rfv_q;

  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (bus.wr_frame_done) begin
          swap    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.wr_frame_done && bus.rd_frame_done)
          swap = 1'b1;
        else if (bus.wr_frame_done)
          state_d = WR_HOLD;
      end
      WR_HOLD: begin
        if (bus.rd_frame_done) begin
          swap    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = EMPTY;
    endcase
    wr_bank_d = wr_bank_q ^ swap;
  end

  // Flags decoded from next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      wr_bank_q  <= BANK0;
      wr_ready_q <= 1'b1;
      rfv_q      <= 1'b0;
      rd_sel_q   <= BANK0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      wr_ready_q <= (state_d != WR_HOLD);
      rfv_q      <= (state_d != EMPTY);
      rd_valid_q <= rd_fire;
      // Select follows the bank actually read, so data holds across swaps.
      if (rd_fire) rd_sel_q <= rd_bank;
    end
  end

`ifdef FRAME_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset)     cnt_q <= '0;
    else if (swap) cnt_q <= cnt_q + 1'b1;
  end
  assign frame_cnt = cnt_q;
`endif

  frame_buf_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank0 (
    .clk    (clk),
    .reset  (reset),
    .we_i   (wr_fire & (wr_bank_q == BANK0)),
    .waddr_i(bus.wr_addr),
    .wdata_i(bus.wr_data),
    .re_i   (rd_fire & (rd_bank == BANK0)),
    .raddr_i(bus.rd_addr),
    .rdata_o(q0)
  );

  frame_buf_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bank1 (
    .clk    (clk),
    .reset  (reset),
    .we_i   (wr_fire & (wr_bank_q == BANK1)),
    .waddr_i(bus.wr_addr),
    .wdata_i(bus.wr_data),
    .re_i   (rd_fire & (rd_bank == BANK1)),
    .raddr_i(bus.rd_addr),
    .rdata_o(q1)
  );

  assign bus.rd_data        = rd_sel_q ? q1 : q0;
  assign bus.rd_data_valid  = rd_valid_q;
  assign bus.wr_ready       = wr_ready_q;
  assign bus.rd_frame_valid = rfv_q;
endmodule
